// File: rtl/lsu_arb_pkg.sv
// Shared types for the LSU data-memory arbiter: buffered memory-op payload and limits.
package lsu_arb_pkg;

  localparam int unsigned NUM_REQ_MAX = 4;
  localparam int unsigned MEM_RD_LAT  = 1;
  localparam int unsigned OP_ADDR_W   = 22;
  localparam int unsigned OP_DATA_W   = 32;

  // One memory operation as held in a requester buffer or driven to the macro.
  typedef struct packed {
    logic [OP_ADDR_W-1:0] addr;
    logic [OP_DATA_W-1:0] data;
    logic [OP_DATA_W-1:0] wr_mask_x;
    logic                 wr_en_x;
  } op_t;

  function automatic op_t op_idle();
    op_t op;
    op.addr      = '0;
    op.data      = '0;
    op.wr_mask_x = '1;
    op.wr_en_x   = 1'b1;
    return op;
  endfunction

endpackage

// File: rtl/lsu_mem_arbiter_if.sv
// Requester-side and memory-side bundle of the LSU data-memory arbiter.
interface lsu_mem_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 22,
  parameter int unsigned DATA_W  = 32
);
  logic [NUM_REQ-1:0]        rq_mem_en_x;
  logic [NUM_REQ-1:0]        rq_wr_en_x;
  logic [NUM_REQ*ADDR_W-1:0] rq_addr;
  logic [NUM_REQ*DATA_W-1:0] rq_data;
  logic [NUM_REQ*DATA_W-1:0] rq_wr_mask_x;
  logic [NUM_REQ-1:0]        rq_lock;
  logic [NUM_REQ-1:0]        rq_rvalid;
  logic [DATA_W-1:0]         rq_rdata;
  logic                      mem_en_x;
  logic                      wr_en_x;
  logic [DATA_W-1:0]         wr_mask_x;
  logic [ADDR_W-1:0]         addr;
  logic [DATA_W-1:0]         data_out;
  logic [DATA_W-1:0]         data_in;

  // Arbiter side.
  modport slave (
    input  rq_mem_en_x, rq_wr_en_x, rq_addr, rq_data, rq_wr_mask_x, data_in,
    output rq_lock, rq_rvalid, rq_rdata, mem_en_x, wr_en_x, wr_mask_x, addr, data_out
  );

  // Requesters plus memory macro side.
  modport master (
    output rq_mem_en_x, rq_wr_en_x, rq_addr, rq_data, rq_wr_mask_x, data_in,
    input  rq_lock, rq_rvalid, rq_rdata, mem_en_x, wr_en_x, wr_mask_x, addr, data_out
  );
endinterface

// File: rtl/lsu_rr_pick.sv
// Round-robin picker: first request at or above the one-hot pointer, wrapping to the lowest.
module lsu_rr_pick #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] ptr_i,
  output logic [N-1:0] gnt_c
);

  logic [N-1:0] upper_c;
  logic [N-1:0] sel_c;

  // ptr-1 marks the positions below the pointer; the lowest set bit of the chosen set wins.
  always_comb begin
    upper_c = req_i & ~(ptr_i - N'(1));
    sel_c   = (|upper_c) ? upper_c : req_i;
    gnt_c   = sel_c & (~sel_c + N'(1));
  end

endmodule

// File: rtl/lsu_mem_arbiter.sv
// Shares one 1-cycle-latency data-memory port between NUM_REQ LSU FUs; losers are buffered
// and locked until served, read data returns via a per-requester valid tag.
module lsu_mem_arbiter
  import lsu_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = OP_ADDR_W,
  parameter int unsigned DATA_W  = OP_DATA_W
) (
  input logic              clk,
  input logic              reset,
  lsu_mem_arbiter_if.slave bus
);

  logic [NUM_REQ-1:0] pend_q, pend_d;
  logic [NUM_REQ-1:0] rv_q, rv_d;
  logic [NUM_REQ-1:0] rr_q, rr_d;
  op_t                buf_q [NUM_REQ];
  op_t                buf_d [NUM_REQ];
  logic [OP_ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [OP_DATA_W-1:0] last_data_q, last_data_d;

  logic [NUM_REQ-1:0] fresh_c;
  logic [NUM_REQ-1:0] gnt_pend_c;
  logic [NUM_REQ-1:0] gnt_fresh_c;
  logic [NUM_REQ-1:0] gnt_c;
  op_t                live_c [NUM_REQ];
  op_t                win_c;

  // Locked requesters are invisible to the fresh class.
  assign fresh_c = ~bus.rq_mem_en_x & ~pend_q;

  lsu_rr_pick #(.N(NUM_REQ)) u_pick_pend (
    .req_i (pend_q),
    .ptr_i (rr_q),
    .gnt_c (gnt_pend_c)
  );

  lsu_rr_pick #(.N(NUM_REQ)) u_pick_fresh (
    .req_i (fresh_c),
    .ptr_i (rr_q),
    .gnt_c (gnt_fresh_c)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      live_c[i].addr      = OP_ADDR_W'(bus.rq_addr[i*ADDR_W +: ADDR_W]);
      live_c[i].data      = OP_DATA_W'(bus.rq_data[i*DATA_W +: DATA_W]);
      live_c[i].wr_mask_x = OP_DATA_W'(bus.rq_wr_mask_x[i*DATA_W +: DATA_W]);
      live_c[i].wr_en_x   = bus.rq_wr_en_x[i];
    end
  end

  // Pending buffers outrank fresh requests; the winner's op comes from its buffer if pending.
  always_comb begin
    gnt_c = (|pend_q) ? gnt_pend_c : gnt_fresh_c;
    win_c = op_idle();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_c[i]) begin
        win_c = pend_q[i] ? buf_q[i] : live_c[i];
      end
    end
  end

  always_comb begin
    pend_d      = pend_q;
    buf_d       = buf_q;
    rv_d        = gnt_c & {NUM_REQ{win_c.wr_en_x}};
    rr_d        = rr_q;
    last_addr_d = last_addr_q;
    last_data_d = last_data_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_c[i]) begin
        pend_d[i] = 1'b0;
      end else if (fresh_c[i]) begin
        pend_d[i] = 1'b1;
        buf_d[i]  = live_c[i];
      end
    end
    if (|gnt_c) begin
      rr_d        = {gnt_c[NUM_REQ-2:0], gnt_c[NUM_REQ-1]};
      last_addr_d = win_c.addr;
      last_data_d = win_c.data;
    end
  end

  // Memory strobes follow the winner in the same cycle; the bus idles (and zeroes) under reset.
  always_comb begin
    bus.mem_en_x  = 1'b1;
    bus.wr_en_x   = 1'b1;
    bus.wr_mask_x = '1;
    bus.addr      = ADDR_W'(last_addr_q);
    bus.data_out  = DATA_W'(last_data_q);
    if (reset) begin
      bus.addr     = '0;
      bus.data_out = '0;
    end else if (|gnt_c) begin
      bus.mem_en_x  = 1'b0;
      bus.wr_en_x   = win_c.wr_en_x;
      bus.wr_mask_x = DATA_W'(win_c.wr_mask_x);
      bus.addr      = ADDR_W'(win_c.addr);
      bus.data_out  = DATA_W'(win_c.data);
    end
  end

  assign bus.rq_lock   = pend_q;
  assign bus.rq_rvalid = rv_q;
  assign bus.rq_rdata  = bus.data_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q      <= '0;
      rv_q        <= '0;
      rr_q        <= NUM_REQ'(1);
      last_addr_q <= '0;
      last_data_q <= '0;
    end else begin
      pend_q      <= pend_d;
      rv_q        <= rv_d;
      rr_q        <= rr_d;
      last_addr_q <= last_addr_d;
      last_data_q <= last_data_d;
    end
  end

  // Buffer contents are meaningless without pend_q, so they carry no reset.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

endmodule
